// File: rtl/uart_loopback.sv
// UART 8O1 echo: RX deserializer -> byte FIFO -> TX serializer sharing one baud divider.
// Only frames with correct odd parity and a valid stop bit are echoed.
module uart_loopback #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned BAUD_DIV   = CLK_FREQ / BAUD,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic clk_50m_i,
  input  logic rst_n_i,
  input  logic uart_rxd_i,
  output logic uart_txd_o
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  // Input synchronizer plus one extra stage for falling-edge detection
  logic rx_s1, rx_s2, rx_prev;

  always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rxd_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // ---------------- RX ----------------
  rx_state_t        rx_state, rx_state_nx;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]       rx_bits, rx_bits_nx;
  logic [7:0]       rx_shift, rx_shift_nx;
  logic             rx_par_ok, rx_par_ok_nx;
  logic             rx_push;

  always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bits   <= '0;
      rx_shift  <= '0;
      rx_par_ok <= 1'b0;
    end else begin
      rx_state  <= rx_state_nx;
      rx_cnt    <= rx_cnt_nx;
      rx_bits   <= rx_bits_nx;
      rx_shift  <= rx_shift_nx;
      rx_par_ok <= rx_par_ok_nx;
    end
  end

  always_comb begin
    rx_state_nx  = rx_state;
    rx_cnt_nx    = rx_cnt + 1'b1;
    rx_bits_nx   = rx_bits;
    rx_shift_nx  = rx_shift;
    rx_par_ok_nx = rx_par_ok;
    rx_push      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nx = '0;
        if (rx_prev && !rx_s2) begin
          rx_state_nx = RX_START;
          rx_bits_nx  = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nx   = '0;
          rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == DIV_LAST) begin
          rx_cnt_nx   = '0;
          rx_shift_nx = {rx_s2, rx_shift[7:1]};
          if (rx_bits == 3'd7) rx_state_nx = RX_PARITY;
          else                 rx_bits_nx  = rx_bits + 1'b1;
        end
      end
      RX_PARITY: begin
        if (rx_cnt == DIV_LAST) begin
          rx_cnt_nx    = '0;
          rx_par_ok_nx = ^rx_shift ^ rx_s2;
          rx_state_nx  = RX_STOP;
        end
      end
      RX_STOP: begin
        // Leave mid-stop-bit so an immediately following start edge is seen
        if (rx_cnt == DIV_LAST) begin
          rx_cnt_nx   = '0;
          rx_push     = rx_s2 && rx_par_ok;
          rx_state_nx = RX_IDLE;
        end
      end
      default: begin
        rx_state_nx = RX_IDLE;
        rx_cnt_nx   = '0;
      end
    endcase
  end

  // ---------------- FIFO ----------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_count;
  logic             fifo_empty, fifo_full, fifo_push, fifo_pop, tx_pop;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FIFO_FULL);
  assign fifo_push  = rx_push && !fifo_full;
  assign fifo_pop   = tx_pop && !fifo_empty;

  always_ff @(posedge clk_50m_i) begin
    if (fifo_push) fifo_mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------- TX ----------------
  tx_state_t        tx_state, tx_state_nx;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_nx;
  logic [2:0]       tx_bit, tx_bit_nx;
  logic [7:0]       tx_data, tx_data_nx;
  logic             txd_nx;

  always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_data    <= '0;
      uart_txd_o <= 1'b1;
    end else begin
      tx_state   <= tx_state_nx;
      tx_cnt     <= tx_cnt_nx;
      tx_bit     <= tx_bit_nx;
      tx_data    <= tx_data_nx;
      uart_txd_o <= txd_nx;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt + 1'b1;
    tx_bit_nx   = tx_bit;
    tx_data_nx  = tx_data;
    tx_pop      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_nx = '0;
        if (!fifo_empty) begin
          tx_pop      = 1'b1;
          tx_data_nx  = fifo_mem[rd_ptr];
          tx_state_nx = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == DIV_LAST) begin
          tx_cnt_nx   = '0;
          tx_bit_nx   = '0;
          tx_state_nx = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt == DIV_LAST) begin
          tx_cnt_nx = '0;
          if (tx_bit == 3'd7) tx_state_nx = TX_PARITY;
          else                tx_bit_nx   = tx_bit + 1'b1;
        end
      end
      TX_PARITY: begin
        if (tx_cnt == DIV_LAST) begin
          tx_cnt_nx   = '0;
          tx_state_nx = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt == DIV_LAST) begin
          tx_cnt_nx = '0;
          if (!fifo_empty) begin
            tx_pop      = 1'b1;
            tx_data_nx  = fifo_mem[rd_ptr];
            tx_state_nx = TX_START;
          end else begin
            tx_state_nx = TX_IDLE;
          end
        end
      end
      default: begin
        tx_state_nx = TX_IDLE;
        tx_cnt_nx   = '0;
      end
    endcase
  end

  // Line level is decoded from the next state so the output flop changes with the state
  always_comb begin
    case (tx_state_nx)
      TX_START:  txd_nx = 1'b0;
      TX_DATA:   txd_nx = tx_data_nx[tx_bit_nx];
      TX_PARITY: txd_nx = ~^tx_data_nx;
      default:   txd_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_loopback.sv
// Directed bench for uart_loopback: drives 8O1 frames on the RX line and decodes the
// echoed frames from the TX line with an independent line monitor.
module tb_uart_loopback;

  localparam int unsigned DIV   = 100;
  localparam int unsigned FRAME = 11 * DIV;

  logic clk = 1'b0;
  logic rst_n;
  logic rxd;
  logic txd;
  int unsigned cyc = 0;
  int passed = 0;
  int total  = 0;

  uart_loopback #(.CLK_FREQ(960_000), .BAUD(9600), .BAUD_DIV(DIV), .FIFO_DEPTH(4)) dut (
    .clk_50m_i (clk),
    .rst_n_i   (rst_n),
    .uart_rxd_i(rxd),
    .uart_txd_o(txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    logic        par;
    logic        stop;
    logic        steady;
    int unsigned start_cyc;
  } tx_frame_t;

  tx_frame_t mon_q[$];

  typedef struct {
    string       name;
    logic [7:0]  data;
    logic        par;
    logic        stop;
    int unsigned bclk;
    logic        echo;
  } vec_t;

  // Decode TX line: each bit sampled at its first and last clock; both must agree
  initial begin : tx_monitor
    tx_frame_t f;
    logic [10:0] a, b;
    forever begin
      @(posedge clk); #1;
      if (rst_n === 1'b1 && txd === 1'b0) begin
        f.start_cyc = cyc;
        for (int i = 0; i < 11; i++) begin
          a[i] = txd;
          repeat (DIV - 1) @(posedge clk);
          #1;
          b[i] = txd;
          if (i < 10) begin
            @(posedge clk); #1;
          end
        end
        f.data   = a[8:1];
        f.par    = a[9];
        f.stop   = a[10];
        f.steady = (a == b) && (a[0] == 1'b0);
        mon_q.push_back(f);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic check_range(input string name, input longint act, input longint lo,
                             input longint hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int unsigned bclk, output int unsigned t0);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < 11; i++) begin
      rxd = bits[i];
      repeat (bclk) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic wait_frames(input int n, input int unsigned budget);
    int unsigned waited = 0;
    while (mon_q.size() < n && waited < budget) begin
      @(posedge clk);
      waited++;
    end
    #1;
  endtask

  initial begin : watchdog
    repeat (98000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin : main
    vec_t        vecs[8];
    logic [7:0]  seq[4];
    logic        seq_par[4];
    int unsigned t0;
    int unsigned t_echo[8];

    vecs[0] = '{"v21_fast",    8'h21, 1'b1, 1'b1,  97, 1'b1};
    vecs[1] = '{"v21_badpar",  8'h21, 1'b0, 1'b1, 100, 1'b0};
    vecs[2] = '{"v5A_badstop", 8'h5A, 1'b1, 1'b0, 100, 1'b0};
    vecs[3] = '{"vCB",         8'hCB, 1'b0, 1'b1, 100, 1'b1};
    vecs[4] = '{"v00",         8'h00, 1'b1, 1'b1, 100, 1'b1};
    vecs[5] = '{"vFF_slow",    8'hFF, 1'b1, 1'b1, 103, 1'b1};
    vecs[6] = '{"v80",         8'h80, 1'b0, 1'b1, 100, 1'b1};
    vecs[7] = '{"v7F_slow",    8'h7F, 1'b0, 1'b1, 103, 1'b1};
    seq[0] = 8'hCB; seq_par[0] = 1'b0;
    seq[1] = 8'h05; seq_par[1] = 1'b1;
    seq[2] = 8'h00; seq_par[2] = 1'b1;
    seq[3] = 8'h21; seq_par[3] = 1'b1;

    // Reset
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("txd_in_reset", txd, 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("txd_after_reset", txd, 1);
    check("fifo_count_after_reset", dut.fifo_count, 0);

    // Single frames
    for (int i = 0; i < 8; i++) begin
      mon_q.delete();
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].bclk, t0);
      if (vecs[i].echo) begin
        wait_frames(1, 2 * FRAME);
        check({vecs[i].name, "_count"}, mon_q.size(), 1);
        if (mon_q.size() >= 1) begin
          check({vecs[i].name, "_data"}, mon_q[0].data, vecs[i].data);
          check({vecs[i].name, "_par"}, mon_q[0].par, vecs[i].par);
          check({vecs[i].name, "_stop"}, mon_q[0].stop, 1);
          check({vecs[i].name, "_bit_width"}, mon_q[0].steady, 1);
          check_range({vecs[i].name, "_latency"}, mon_q[0].start_cyc - t0, 1050, 1058);
        end
      end else begin
        repeat (FRAME) @(posedge clk);
        #1 check({vecs[i].name, "_dropped"}, mon_q.size(), 0);
      end
    end

    // Eight frames from a 3% fast sender: echoes run back-to-back, in order
    mon_q.delete();
    for (int k = 0; k < 8; k++) send_frame(seq[k % 4], seq_par[k % 4], 1'b1, 97, t0);
    wait_frames(8, 3 * FRAME);
    check("burst_count", mon_q.size(), 8);
    if (mon_q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        check($sformatf("burst_data%0d", k), mon_q[k].data, seq[k % 4]);
        check($sformatf("burst_par%0d", k), mon_q[k].par, seq_par[k % 4]);
        t_echo[k] = mon_q[k].start_cyc;
      end
      for (int k = 1; k < 8; k++)
        check($sformatf("burst_gap%0d", k), t_echo[k] - t_echo[k-1], FRAME);
    end

    // Short low glitch is a false start
    mon_q.delete();
    @(negedge clk) rxd = 1'b0;
    repeat (38) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * FRAME) @(posedge clk);
    #1 check("glitch_no_echo", mon_q.size(), 0);

    // Overflow: hold TX off while six frames arrive; only the first four survive
    mon_q.delete();
    force dut.fifo_empty = 1'b1;
    for (int k = 0; k < 6; k++) send_frame(8'(8'h11 * (k + 1)), 1'b1, 1'b1, DIV, t0);
    repeat (10) @(posedge clk);
    #1 check("overflow_fifo_count", dut.fifo_count, 4);
    check("overflow_tx_stalled", mon_q.size(), 0);
    release dut.fifo_empty;
    wait_frames(4, 5 * FRAME);
    repeat (2 * FRAME) @(posedge clk);
    #1 check("overflow_echo_count", mon_q.size(), 4);
    if (mon_q.size() >= 4)
      for (int k = 0; k < 4; k++)
        check($sformatf("overflow_data%0d", k), mon_q[k].data, 8'h11 * (k + 1));
    check("overflow_fifo_drained", dut.fifo_count, 0);

    // Reset during echoed data bits (0x21: d2 is 0)
    mon_q.delete();
    send_frame(8'h21, 1'b1, 1'b1, DIV, t0);
    while (cyc < t0 + 1400) @(negedge clk);
    check("pre_reset_txd_low", txd, 0);
    rst_n = 1'b0;
    #1 check("reset_async_txd", txd, 1);
    check("reset_fifo_count", dut.fifo_count, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME) @(posedge clk);
    mon_q.delete();
    repeat (FRAME) @(posedge clk);
    #1 check("post_reset_idle", mon_q.size(), 0);
    check("post_reset_txd", txd, 1);
    send_frame(8'hA5, 1'b1, 1'b1, DIV, t0);
    wait_frames(1, 2 * FRAME);
    check("post_reset_echo_count", mon_q.size(), 1);
    if (mon_q.size() >= 1) check("post_reset_echo_data", mon_q[0].data, 8'hA5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
